// File: rtl/reset_sequencer.sv
// reset_sequencer: ordered release of NUM_STAGES reset domains after a hold period,
// with soft restart, per-stage timeout, fault stop and status outputs.
//   clk, reset_n (async low)   : clock and chip reset
//   soft_reset (sync high)     : restart the sequence from HOLD
//   stage_done[N]              : per-stage ready level
//   stage_reset[N]             : per-stage active-high reset, bit 0 released first
//   seq_stage                  : index of the stage currently awaited
//   all_released / timeout / busy : status
module reset_sequencer #(
  parameter int NUM_STAGES       = 4,
  parameter int HOLD_CYCLES      = 15,
  parameter int TIMEOUT_CYCLES   = 0,
  parameter bit TIMEOUT_CONTINUE = 1'b0,
  parameter int CNT_WIDTH        = 32,
  localparam int IDX_W =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  soft_reset,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic [IDX_W-1:0]      seq_stage,
  output logic                  all_released,
  output logic                  timeout,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_SYNC, S_HOLD, S_WAIT, S_RUN, S_FAULT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LD =
    CNT_WIDTH'(HOLD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TMO =
    CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_STAGES - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    settle_q, settle_d;
  logic                    tmo_q, tmo_d;
  logic                    meta_q;
  logic                    adv;
  logic [NUM_STAGES-1:0]   sr_d;
  logic                    busy_d;

  // First synchronizer flop; the SYNC state register
  // acts as the second one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q       <= 1'b0;
      state_q      <= S_SYNC;
      cnt_q        <= '0;
      idx_q        <= '0;
      settle_q     <= 1'b0;
      tmo_q        <= 1'b0;
      stage_reset  <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      meta_q       <= 1'b1;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      tmo_q        <= tmo_d;
      stage_reset  <= sr_d;
      all_released <= (sr_d == '0);
      busy         <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    settle_d = 1'b0;
    tmo_d    = tmo_q;
    adv      = 1'b0;
    if (soft_reset) begin
      state_d = S_HOLD;
      cnt_d   = HOLD_LD;
      idx_d   = '0;
      tmo_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          if (meta_q) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_d  = S_WAIT;
            idx_d    = '0;
            settle_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          // done is ignored in the settle cycle
          if (settle_q) begin
            cnt_d = cnt_q + 1'b1;
          end else if (stage_done[idx_q]) begin
            adv = 1'b1;
          end else if (TMO_EN && cnt_q >= TMO) begin
            tmo_d = 1'b1;
            if (TIMEOUT_CONTINUE) adv = 1'b1;
            else state_d = S_FAULT;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (adv) begin
            if (idx_q == LAST) begin
              state_d = S_RUN;
            end else begin
              idx_d    = idx_q + 1'b1;
              cnt_d    = '0;
              settle_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Mask is a pure function of state/index, so bits
  // can only ever be released in ascending order.
  always_comb begin
    sr_d = '1;
    unique case (state_d)
      S_WAIT, S_FAULT: begin
        for (int i = 0; i < NUM_STAGES; i++)
          sr_d[i] = (i > int'(idx_d));
      end
      S_RUN: sr_d = '0;
      default: sr_d = '1;
    endcase
    busy_d = (state_d == S_SYNC) ||
             (state_d == S_HOLD) ||
             (state_d == S_WAIT);
  end

  assign seq_stage = idx_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of reset_sequencer
// with three timeout configurations plus a random soak.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       soft_reset;
  logic [3:0] stage_done;

  logic [3:0] sr0, sr1, sr2;
  logic [1:0] seq0, seq1, seq2;
  logic       ar0, ar1, ar2;
  logic       to0, to1, to2;
  logic       bz0, bz1, bz2;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_sequencer u0 (
    .clk(clk), .reset_n(reset_n),
    .soft_reset(soft_reset), .stage_done(stage_done),
    .stage_reset(sr0), .seq_stage(seq0),
    .all_released(ar0), .timeout(to0), .busy(bz0)
  );

  reset_sequencer #(
    .TIMEOUT_CYCLES(8), .TIMEOUT_CONTINUE(1'b0)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .soft_reset(soft_reset), .stage_done(stage_done),
    .stage_reset(sr1), .seq_stage(seq1),
    .all_released(ar1), .timeout(to1), .busy(bz1)
  );

  reset_sequencer #(
    .TIMEOUT_CYCLES(8), .TIMEOUT_CONTINUE(1'b1)
  ) u2 (
    .clk(clk), .reset_n(reset_n),
    .soft_reset(soft_reset), .stage_done(stage_done),
    .stage_reset(sr2), .seq_stage(seq2),
    .all_released(ar2), .timeout(to2), .busy(bz2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After this returns, the next posedge is edge 0.
  task automatic do_reset(input logic [3:0] d);
    @(negedge clk);
    reset_n    = 1'b0;
    soft_reset = 1'b0;
    stage_done = d;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] therm(input logic [3:0] s);
    logic [3:0] t;
    int z;
    t = 4'hF;
    z = 0;
    for (int i = 0; i < 4; i++)
      if (!s[i]) z++;
    return t << z;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    soft_reset = 1'b0;
    stage_done = 4'hF;
    #12;
    chk("rst_sr",   sr0,  4'hF);
    chk("rst_seq",  seq0, 2'd0);
    chk("rst_ar",   ar0,  1'b0);
    chk("rst_to",   to0,  1'b0);
    chk("rst_busy", bz0,  1'b1);

    // 1: nominal sequence, all done
    do_reset(4'hF);
    step(17);
    chk("t1_e16", sr0, 4'hF);
    step(1);
    chk("t1_e17", sr0, 4'hE);
    chk("t1_seq0", seq0, 2'd0);
    step(2);
    chk("t1_e19", sr0, 4'hC);
    chk("t1_seq1", seq0, 2'd1);
    step(2);
    chk("t1_e21", sr0, 4'h8);
    step(2);
    chk("t1_e23", sr0, 4'h0);
    chk("t1_ar", ar0, 1'b1);
    chk("t1_bz23", bz0, 1'b1);
    step(2);
    chk("t1_bz25", bz0, 1'b0);

    // 5: async reset in RUN, then SYNC delay
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_async_sr", sr0, 4'hF);
    chk("t5_async_ar", ar0, 1'b0);
    chk("t5_async_bz", bz0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    step(17);
    chk("t5_e16", sr0, 4'hF);
    step(1);
    chk("t5_e17", sr0, 4'hE);

    // 2: done[2] stuck low, no timeout on u0
    do_reset(4'b1011);
    step(22);
    chk("t2_e21_sr", sr0, 4'h8);
    chk("t2_e21_seq", seq0, 2'd2);
    step(50);
    chk("t2_mid_sr", sr0, 4'h8);
    chk("t2_mid_bz", bz0, 1'b1);
    chk("t2_u1_sr", sr1, 4'h8);
    chk("t2_u1_to", to1, 1'b1);
    chk("t2_u1_bz", bz1, 1'b0);
    chk("t2_u1_seq", seq1, 2'd2);
    step(50);
    chk("t2_end_sr", sr0, 4'h8);
    chk("t2_end_seq", seq0, 2'd2);
    chk("t2_end_to", to0, 1'b0);
    stage_done = 4'hF;
    step(1);
    chk("t2_rel_sr", sr0, 4'h0);
    chk("t2_rel_ar", ar0, 1'b1);
    step(2);
    chk("t2_run_bz", bz0, 1'b0);
    stage_done = 4'h0;
    step(3);
    chk("t2_drop_sr", sr0, 4'h0);
    chk("t2_drop_ar", ar0, 1'b1);

    // 3: timeout on stage 1
    do_reset(4'b1101);
    step(28);
    chk("t3_e27_to", to1, 1'b0);
    chk("t3_e27_bz", bz1, 1'b1);
    chk("t3_e27_sr", sr1, 4'hC);
    step(1);
    chk("t3_u1_to", to1, 1'b1);
    chk("t3_u1_sr", sr1, 4'hC);
    chk("t3_u1_bz", bz1, 1'b0);
    chk("t3_u1_seq", seq1, 2'd1);
    chk("t3_u1_ar", ar1, 1'b0);
    chk("t3_u2_to", to2, 1'b1);
    chk("t3_u2_sr", sr2, 4'h8);
    chk("t3_u2_seq", seq2, 2'd2);
    step(4);
    chk("t3_u2_run_sr", sr2, 4'h0);
    chk("t3_u2_run_bz", bz2, 1'b0);
    chk("t3_u2_run_to", to2, 1'b1);
    chk("t3_u1_hold", sr1, 4'hC);
    chk("t3_u0_to", to0, 1'b0);
    chk("t3_u0_bz", bz0, 1'b1);
    chk("t3_u0_seq", seq0, 2'd1);

    // done and timeout on the same edge
    do_reset(4'b1101);
    step(28);
    stage_done = 4'hF;
    step(1);
    chk("tw_to", to1, 1'b0);
    chk("tw_sr", sr1, 4'h8);
    chk("tw_seq", seq1, 2'd2);

    // 4: soft reset while waiting on stage 2
    do_reset(4'b1011);
    step(31);
    chk("t4_pre_to", to1, 1'b1);
    soft_reset = 1'b1;
    step(1);
    chk("t4_sr0", sr0, 4'hF);
    chk("t4_seq0", seq0, 2'd0);
    chk("t4_bz0", bz0, 1'b1);
    chk("t4_sr1", sr1, 4'hF);
    chk("t4_to1", to1, 1'b0);
    chk("t4_bz1", bz1, 1'b1);
    step(1);
    chk("t4_held", sr0, 4'hF);
    soft_reset = 1'b0;
    stage_done = 4'hF;
    step(15);
    chk("t4_e47", sr0, 4'hF);
    step(1);
    chk("t4_e48", sr0, 4'hE);

    // 6: random soak
    do_reset(4'hF);
    step(1);
    for (int i = 0; i < 10000; i++) begin
      stage_done = 4'($urandom);
      soft_reset = ($urandom_range(0, 199) == 0);
      step(1);
      chk("t6_ord0", sr0, therm(sr0));
      chk("t6_ar0", ar0, (sr0 == 4'h0));
      chk("t6_ord2", sr2, therm(sr2));
      chk("t6_ar2", ar2, (sr2 == 4'h0));
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
